evm_ballot_ctrl: RTL and testbench
==================================

Name: evm_ballot_ctrl

Overview:
- Ballot-unit controller downstream of the 1 Hz divider; consumes its 1 Hz square wave (clk1) as a seconds time base.
- Accepts one candidate press per voter, tallies per-candidate and total votes, then locks the ballot for LOCK_SEC seconds before re-arming.
- Runs entirely on clk_100MHz; clk1 is treated as data and is synchronised and edge-detected internally, never used as a clock.

Parameters:
- N_CAND, 4, number of candidate buttons/counters (2..8).
- CNT_W, 8, width of each per-candidate counter (saturating).
- TOT_W, 10, width of total vote counter (saturating).
- LOCK_SEC, 5, lockout length in seconds after each accepted vote (1..15).

Ports:
- clk_100MHz  in  1  system clock, 100 MHz Basys 3 oscillator.
- rst_n  in  1  asynchronous active-low reset.
- clk1  in  1  1 Hz square wave from divider; asynchronous to logic, sampled.
- ballot_en  in  1  presiding-officer enable; level.
- clear_counts  in  1  level; zeroes all tallies, honoured only in CLOSED.
- cand_btn  in  N_CAND  debounced candidate buttons, active-high, asynchronous.
- vote_counts  out  N_CAND*CNT_W  packed tallies; candidate i at [i*CNT_W +: CNT_W].
- total_votes  out  TOT_W  sum of accepted votes.
- ready  out  1  high in READY.
- locked  out  1  high in LOCKED.
- secs_left  out  4  remaining lockout seconds; 0 outside LOCKED.
- vote_pulse  out  1  one-cycle strobe per accepted vote.
- err_multi  out  1  one-cycle strobe when multiple buttons rise in the same cycle.

Behaviour:
- Reset (async on rst_n low): state CLOSED; all outputs, counters, synchroniser and edge flops 0.
- clk1 path: 2-FF synchroniser s1->s2, history s3; sec_tick = s2 & ~s3, exactly one cycle per clk1 rising edge, asserted 2 clock edges after clk1 is first sampled high.
- cand_btn path: per-bit 2-FF synchroniser plus history flop; press[i] = rising edge, one cycle. Held buttons never generate repeat presses.
- FSM CLOSED: ready=0, locked=0, presses ignored. If clear_counts=1, all vote_counts and total_votes go to 0 next cycle. If ballot_en=1, go to READY next cycle. clear_counts and ballot_en both high: clear and transition in the same cycle.
- FSM READY: ready=1. Priority order:
  1. ballot_en=0 -> CLOSED; any same-cycle press is ignored.
  2. popcount(press)>1 -> err_multi pulse, no count, stay READY.
  3. popcount(press)==1 -> next edge: vote_counts[i]+1 and total_votes+1 (each saturating at all-ones independently), vote_pulse=1 for one cycle, secs_left<=LOCK_SEC, state LOCKED.
- FSM LOCKED: locked=1, ready=0. Presses are ignored and not queued; err_multi is never raised. On sec_tick: if secs_left>1, decrement; if secs_left==1, set secs_left=0 and go to READY when ballot_en=1, else CLOSED. ballot_en falling mid-lock does not shorten the lock.
- Lock duration is between LOCK_SEC-1 and LOCK_SEC seconds; the first tick phase is arbitrary.
- clear_counts is ignored in READY and LOCKED.
- Outputs are registered. ready, locked, and secs_left change on the same edge as the state register.

Test Plan:
- Reset: drive rst_n=0 mid-LOCKED with secs_left=3 -> all outputs 0 and state CLOSED immediately, without waiting for a clock edge.
- Single vote: ballot_en=1, press cand_btn[2] -> exactly one vote_pulse; vote_counts[2]=1, total_votes=1, locked=1, secs_left=5. Then 5 sec_ticks (bench drives clk1 with a 20-cycle period) -> secs_left sequence 4,3,2,1,0, then ready=1.
- Lockout and hold: press cand_btn[0] during LOCKED -> no count change. Keep cand_btn[1] held across the lock end -> no vote on re-arm. Release and press again -> vote_counts[1]=1.
- Multi-press: cand_btn=4'b0101 rising in the same cycle while READY -> err_multi=1 for one cycle, all counts unchanged, still READY.
- Saturation: with CNT_W=2, 5 votes for candidate 3 -> vote_counts[3] holds at 3 and total_votes=5.
- Close and clear: drop ballot_en during LOCKED -> countdown completes, then CLOSED. Assert clear_counts -> all tallies 0. Assert clear_counts in READY -> tallies unchanged.

Source files
------------

// File: rtl/evm_ballot_if.sv
// Ballot-unit bus: presiding-officer controls, candidate buttons and tally/status outputs.
// The controller takes the slave side; the panel/bench drives the master side.
interface evm_ballot_if #(
  parameter int unsigned N_CAND = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned TOT_W  = 10
);
  logic                      ballot_en;
  logic                      clear_counts;
  logic [N_CAND-1:0]         cand_btn;
  logic [N_CAND*CNT_W-1:0]   vote_counts;
  logic [TOT_W-1:0]          total_votes;
  logic                      ready;
  logic                      locked;
  logic [3:0]                secs_left;
  logic                      vote_pulse;
  logic                      err_multi;

  modport master (
    output ballot_en, clear_counts, cand_btn,
    input  vote_counts, total_votes, ready, locked, secs_left, vote_pulse, err_multi
  );

  modport slave (
    input  ballot_en, clear_counts, cand_btn,
    output vote_counts, total_votes, ready, locked, secs_left, vote_pulse, err_multi
  );
endinterface

// File: rtl/evm_ballot_ctrl.sv
// Ballot controller: one vote per voter, saturating tallies, then a seconds-based lockout
// timed from a synchronised 1 Hz input before re-arming.
module evm_ballot_ctrl #(
  parameter int unsigned N_CAND   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TOT_W    = 10,
  parameter int unsigned LOCK_SEC = 5
) (
  input  logic         clk_100MHz,
  input  logic         rst_n,
  input  logic         clk1,
  evm_ballot_if.slave  bus
);
  localparam int unsigned SelW = (N_CAND > 1) ? $clog2(N_CAND) : 1;

  typedef enum logic [1:0] {StClosed, StReady, StLocked} state_e;

  state_e               state_q, state_d;
  logic                 clk1_s1_q, clk1_s2_q, clk1_s3_q;
  logic [N_CAND-1:0]    btn_s1_q, btn_s2_q, btn_s3_q;
  logic [CNT_W-1:0]     cnt_q [N_CAND];
  logic [CNT_W-1:0]     cnt_d [N_CAND];
  logic [TOT_W-1:0]     tot_q, tot_d;
  logic [3:0]           secs_q, secs_d;
  logic                 ready_q, locked_q;
  logic                 pulse_q, pulse_d;
  logic                 err_q, err_d;

  logic                 sec_tick;
  logic [N_CAND-1:0]    press;
  logic [3:0]           n_press;
  logic [SelW-1:0]      sel;

  always_comb begin
    sec_tick = clk1_s2_q & ~clk1_s3_q;
    press    = btn_s2_q & ~btn_s3_q;
    n_press  = '0;
    sel      = '0;
    for (int i = 0; i < int'(N_CAND); i++) begin
      n_press = n_press + 4'(press[i]);
      if (press[i]) sel = SelW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tot_d   = tot_q;
    secs_d  = secs_q;
    pulse_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StClosed: begin
        if (bus.clear_counts) begin
          for (int i = 0; i < int'(N_CAND); i++) cnt_d[i] = '0;
          tot_d = '0;
        end
        if (bus.ballot_en) state_d = StReady;
      end
      StReady: begin
        // Disable wins over any same-cycle press; multi-press is flagged but never counted.
        if (!bus.ballot_en) begin
          state_d = StClosed;
        end else if (n_press > 4'd1) begin
          err_d = 1'b1;
        end else if (n_press == 4'd1) begin
          if (~&cnt_q[sel]) cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
          if (~&tot_q)      tot_d      = tot_q + TOT_W'(1);
          pulse_d = 1'b1;
          secs_d  = 4'(LOCK_SEC);
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (sec_tick) begin
          if (secs_q > 4'd1) begin
            secs_d = secs_q - 4'd1;
          end else begin
            secs_d  = '0;
            state_d = bus.ballot_en ? StReady : StClosed;
          end
        end
      end
      default: state_d = StClosed;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClosed;
      clk1_s1_q <= 1'b0;
      clk1_s2_q <= 1'b0;
      clk1_s3_q <= 1'b0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      btn_s3_q  <= '0;
      for (int i = 0; i < int'(N_CAND); i++) cnt_q[i] <= '0;
      tot_q     <= '0;
      secs_q    <= '0;
      ready_q   <= 1'b0;
      locked_q  <= 1'b0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk1_s1_q <= clk1;
      clk1_s2_q <= clk1_s1_q;
      clk1_s3_q <= clk1_s2_q;
      btn_s1_q  <= bus.cand_btn;
      btn_s2_q  <= btn_s1_q;
      btn_s3_q  <= btn_s2_q;
      cnt_q     <= cnt_d;
      tot_q     <= tot_d;
      secs_q    <= secs_d;
      ready_q   <= (state_d == StReady);
      locked_q  <= (state_d == StLocked);
      pulse_q   <= pulse_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    bus.vote_counts = '0;
    for (int i = 0; i < int'(N_CAND); i++) bus.vote_counts[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign bus.total_votes = tot_q;
  assign bus.ready       = ready_q;
  assign bus.locked      = locked_q;
  assign bus.secs_left   = secs_q;
  assign bus.vote_pulse  = pulse_q;
  assign bus.err_multi   = err_q;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Bench for evm_ballot_ctrl: directed scenarios plus random traffic, every cycle compared
// against an event-level model of the ballot rules.
module tb_evm_ballot_ctrl;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned TW = 10;
  localparam int unsigned LS = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clk1  = 1'b0;

  evm_ballot_if #(.N_CAND(N), .CNT_W(CW), .TOT_W(TW)) bus ();

  evm_ballot_ctrl #(.N_CAND(N), .CNT_W(CW), .TOT_W(TW), .LOCK_SEC(LS)) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .clk1       (clk1),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_pulse  = 0;
  int n_err    = 0;
  int vote_secs = 0;

  // Model: 0 closed, 1 ready, 2 locked.
  int       m_state, m_secs, m_tot;
  int       m_cnt [N];
  logic     m_pulse, m_err;
  logic     c_h [3];          // clk1 samples at the previous three edges, newest first
  logic [N-1:0] b_h [3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_tot = 0; m_pulse = 1'b0; m_err = 1'b0;
    for (int i = 0; i < int'(N); i++) m_cnt[i] = 0;
    for (int i = 0; i < 3; i++) begin c_h[i] = 1'b0; b_h[i] = '0; end
  endtask

  // Inputs seen at an edge act two edges later (two-stage synchroniser + edge history).
  task automatic model_edge();
    logic tick;
    logic [N-1:0] press;
    int np, sel;
    tick  = c_h[1] & ~c_h[2];
    press = b_h[1] & ~b_h[2];
    c_h[2] = c_h[1]; c_h[1] = c_h[0]; c_h[0] = clk1;
    b_h[2] = b_h[1]; b_h[1] = b_h[0]; b_h[0] = bus.cand_btn;
    np  = $countones(press);
    sel = 0;
    for (int i = 0; i < int'(N); i++) if (press[i]) sel = i;
    m_pulse = 1'b0;
    m_err   = 1'b0;
    case (m_state)
      0: begin
        if (bus.clear_counts) begin
          m_tot = 0;
          for (int i = 0; i < int'(N); i++) m_cnt[i] = 0;
        end
        if (bus.ballot_en) m_state = 1;
      end
      1: begin
        if (!bus.ballot_en) m_state = 0;
        else if (np > 1) m_err = 1'b1;
        else if (np == 1) begin
          if (m_cnt[sel] < (1 << CW) - 1) m_cnt[sel]++;
          if (m_tot < (1 << TW) - 1) m_tot++;
          m_pulse = 1'b1;
          m_secs  = LS;
          m_state = 2;
        end
      end
      default: begin
        if (tick) begin
          m_secs--;
          if (m_secs == 0) m_state = bus.ballot_en ? 1 : 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    logic [N*CW-1:0] e;
    e = '0;
    for (int i = 0; i < int'(N); i++) e[i*CW +: CW] = CW'(m_cnt[i]);
    check_eq("vote_counts", bus.vote_counts, e);
    check_eq("total_votes", bus.total_votes, m_tot);
    check_eq("ready", bus.ready, m_state == 1);
    check_eq("locked", bus.locked, m_state == 2);
    check_eq("secs_left", bus.secs_left, m_secs);
    check_eq("vote_pulse", bus.vote_pulse, m_pulse);
    check_eq("err_multi", bus.err_multi, m_err);
  endtask

  // clk1 runs with a 20-cycle period, derived from the bench cycle count.
  task automatic step();
    clk1 = ((cyc % 20) >= 10);
    cyc++;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (bus.vote_pulse) begin n_pulse++; vote_secs = bus.secs_left; end
    if (bus.err_multi) n_err++;
  endtask

  task automatic wait_until(input string tag, input logic want_ready, input logic want_locked,
                            input int max);
    int k;
    k = 0;
    while (!(bus.ready == want_ready && bus.locked == want_locked) && k < max) begin
      step();
      k++;
    end
    check_eq(tag, {bus.ready, bus.locked}, {want_ready, want_locked});
  endtask

  task automatic press(input int c);
    bus.cand_btn = '0;
    bus.cand_btn[c] = 1'b1;
    repeat (4) step();
    bus.cand_btn = '0;
    step();
  endtask

  initial begin
    int p0, e0;
    logic [N*CW-1:0] snap;
    logic [TW-1:0]   tsnap;
    bus.ballot_en = 1'b0; bus.clear_counts = 1'b0; bus.cand_btn = '0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // Single vote and full countdown.
    bus.ballot_en = 1'b1;
    repeat (3) step();
    check_eq("ready_after_en", bus.ready, 1'b1);
    p0 = n_pulse;
    press(2);
    check_eq("single_pulse", n_pulse - p0, 1);
    check_eq("secs_at_vote", vote_secs, LS);
    check_eq("vc2_one", bus.vote_counts[2*CW +: CW], 1);
    wait_until("rearm1", 1'b1, 1'b0, 200);

    // Presses during lock are dropped; a button held across re-arm does not vote.
    press(3);
    snap = bus.vote_counts;
    bus.cand_btn = 4'b0001; repeat (4) step();
    bus.cand_btn = 4'b0010;
    wait_until("rearm2", 1'b1, 1'b0, 200);
    repeat (10) step();
    check_eq("hold_no_vote", bus.vote_counts, snap);
    bus.cand_btn = '0; repeat (3) step();
    press(1);
    check_eq("vc1_one", bus.vote_counts[1*CW +: CW], 1);
    wait_until("rearm3", 1'b1, 1'b0, 200);

    // Simultaneous rising edges.
    snap = bus.vote_counts; e0 = n_err;
    bus.cand_btn = 4'b0101; repeat (4) step();
    check_eq("multi_err", n_err - e0, 1);
    check_eq("multi_ready", bus.ready, 1'b1);
    check_eq("multi_counts", bus.vote_counts, snap);
    bus.cand_btn = '0; repeat (2) step();

    // Saturation of a 2-bit counter.
    for (int v = 0; v < 5; v++) begin
      press(3);
      wait_until("rearm_sat", 1'b1, 1'b0, 200);
    end
    check_eq("vc3_sat", bus.vote_counts[3*CW +: CW], 3);
    check_eq("total_8", bus.total_votes, 8);

    // Disable mid-lock, then clear in CLOSED; clear in READY is ignored.
    press(0);
    bus.ballot_en = 1'b0;
    wait_until("closed", 1'b0, 1'b0, 200);
    check_eq("closed_total", bus.total_votes, 9);
    bus.clear_counts = 1'b1; repeat (2) step(); bus.clear_counts = 1'b0;
    check_eq("clear_total", bus.total_votes, 0);
    check_eq("clear_counts", bus.vote_counts, 0);
    bus.ballot_en = 1'b1;
    wait_until("reopen", 1'b1, 1'b0, 10);
    press(0);
    wait_until("rearm4", 1'b1, 1'b0, 200);
    tsnap = bus.total_votes;
    bus.clear_counts = 1'b1; repeat (3) step(); bus.clear_counts = 1'b0;
    check_eq("clear_in_ready", bus.total_votes, tsnap);

    // Asynchronous reset in the middle of a lock.
    press(2);
    for (int k = 0; k < 200 && bus.secs_left != 4'd3; k++) step();
    check_eq("secs_three", bus.secs_left, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_counts", bus.vote_counts, 0);
    check_eq("rst_total", bus.total_votes, 0);
    check_eq("rst_locked", bus.locked, 1'b0);
    check_eq("rst_secs", bus.secs_left, 0);
    check_eq("rst_ready", bus.ready, 1'b0);
    check_eq("rst_pulse", bus.vote_pulse, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;

    // Random traffic.
    bus.ballot_en = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(199) == 0) bus.ballot_en = ~bus.ballot_en;
      bus.clear_counts = ($urandom_range(49) == 0);
      if ($urandom_range(5) == 0) bus.cand_btn = N'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
